// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster counters, pixel-aligned sync/blank, head-to-RGB colour
//            mux, and the frame-divided move_clock pulse for the game logic.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int MOVE_DIV   = 6,
    parameter int PIPE_DELAY = 1
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        head,
    output logic [11:0] CounterX,
    output logic [11:0] CounterY,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_tick,
    output logic        move_clock
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] C_H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] C_V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] C_H_ACTIVE   = 12'(H_ACTIVE);
    localparam logic [11:0] C_V_ACTIVE   = 12'(V_ACTIVE);
    localparam logic [11:0] C_H_ACT_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] C_V_ACT_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] C_HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] C_HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] C_VS_START   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] C_VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0]  C_MOVE_LAST  = 8'(MOVE_DIV - 1);

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
        logic border;
    } tim_t;

    localparam tim_t C_TIM_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, border: 1'b0};

    logic [11:0] cnt_x_q, cnt_x_d;
    logic [11:0] cnt_y_q, cnt_y_d;
    tim_t [PIPE_DELAY-1:0] pipe_q, pipe_d;
    tim_t        w_raw;
    tim_t        w_last;
    logic        w_h_wrap;
    logic        w_tick;
    logic        hs_q, vs_q, blank_n_q;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_tick_q;
    logic        move_clock_q;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        move_d;

    // Raster counters
    always_comb begin
        w_h_wrap = (cnt_x_q == C_H_LAST);
        cnt_x_d  = w_h_wrap ? 12'd0 : cnt_x_q + 12'd1;
        cnt_y_d  = cnt_y_q;
        if (w_h_wrap) begin
            cnt_y_d = (cnt_y_q == C_V_LAST) ? 12'd0 : cnt_y_q + 12'd1;
        end
    end

    // Timing decoded from the counters in the cycle they are presented
    always_comb begin
        w_raw.blank_n = (cnt_x_q < C_H_ACTIVE) && (cnt_y_q < C_V_ACTIVE);
        w_raw.hs_n    = !((cnt_x_q >= C_HS_START) && (cnt_x_q < C_HS_END));
        w_raw.vs_n    = !((cnt_y_q >= C_VS_START) && (cnt_y_q < C_VS_END));
        w_raw.border  = w_raw.blank_n &&
                        ((cnt_x_q == 12'd0) || (cnt_x_q == C_H_ACT_LAST) ||
                         (cnt_y_q == 12'd0) || (cnt_y_q == C_V_ACT_LAST));
    end

    always_comb begin
        pipe_d[0] = w_raw;
        for (int s = 1; s < PIPE_DELAY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    assign w_last = pipe_q[PIPE_DELAY-1];

    // head arrives in the same cycle as w_last, so both feed the same colour register
    always_comb begin
        rgb_d = 24'h000000;
        if (!w_last.blank_n) begin
            rgb_d = 24'h000000;
        end else if (head) begin
            rgb_d = 24'h00FF00;
        end else if (w_last.border) begin
            rgb_d = 24'hFFFFFF;
        end
    end

    always_comb begin
        w_tick = (cnt_x_q == 12'd0) && (cnt_y_q == C_V_ACTIVE);
        fcnt_d = fcnt_q;
        move_d = 1'b0;
        if (!start) begin
            fcnt_d = 8'd0;
        end else if (w_tick) begin
            if (fcnt_q == C_MOVE_LAST) begin
                fcnt_d = 8'd0;
                move_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            cnt_x_q      <= 12'd0;
            cnt_y_q      <= 12'd0;
            for (int s = 0; s < PIPE_DELAY; s++) begin
                pipe_q[s] <= C_TIM_IDLE;
            end
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_n_q    <= 1'b0;
            rgb_q        <= 24'h000000;
            frame_tick_q <= 1'b0;
            move_clock_q <= 1'b0;
            fcnt_q       <= 8'd0;
        end else begin
            cnt_x_q      <= cnt_x_d;
            cnt_y_q      <= cnt_y_d;
            pipe_q       <= pipe_d;
            hs_q         <= w_last.hs_n;
            vs_q         <= w_last.vs_n;
            blank_n_q    <= w_last.blank_n;
            rgb_q        <= rgb_d;
            frame_tick_q <= w_tick;
            move_clock_q <= move_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign CounterX    = cnt_x_q;
    assign CounterY    = cnt_y_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign frame_tick  = frame_tick_q;
    assign move_clock  = move_clock_q;

endmodule
`default_nettype wire
